// File: rtl/nano_trace_pkg.sv
// Shared types and constants for the Nano trace UART streamer.
package nano_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int unsigned FRAME_BYTES = 7;
  localparam int unsigned SNAP_W      = 48;

  // Byte idx of a frame: 0 is sync, then state, flags, R LSB..MSB.
  function automatic logic [7:0] frame_byte(input logic [SNAP_W-1:0] snap,
                                            input logic [2:0]        idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = snap[7:0];
      3'd2:    b = snap[15:8];
      3'd3:    b = snap[23:16];
      3'd4:    b = snap[31:24];
      3'd5:    b = snap[39:32];
      3'd6:    b = snap[47:40];
      default: b = '1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nano_trace_uart_if.sv
// Monitor-bus and status bundle between the CPU side and the trace streamer.
interface nano_trace_uart_if;
  logic        EN;
  logic        CLR_OVF;
  logic [7:0]  STATE_IN;
  logic [7:0]  FLAGS_IN;
  logic [31:0] R_IN;
  logic        TX;
  logic        BUSY;
  logic        OVF;

  modport master (output EN, CLR_OVF, STATE_IN, FLAGS_IN, R_IN,
                  input  TX, BUSY, OVF);
  modport slave  (input  EN, CLR_OVF, STATE_IN, FLAGS_IN, R_IN,
                  output TX, BUSY, OVF);
endinterface

// File: rtl/nano_trace_uart_tx8.sv
// Single-byte 8N1 serializer. ready is high in IDLE and on the last STOP
// cycle, so a load there chains the next byte with no idle gap.
module uart_tx8
  import nano_trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign ready   = (state == IDLE) || ((state == STOP) && bit_end);

  // Bit timing and line driver; tx is taken straight from this flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shreg <= data;
            cnt   <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (load) begin
              shreg <= data;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/nano_trace_uart.sv
// Trace streamer top: change detector, snapshot FIFO and frame sequencing
// around a byte serializer.
module nano_trace_uart
  import nano_trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 27,
  parameter int unsigned DEPTH        = 4
) (
  input  logic               CLK,
  input  logic               NRST,
  nano_trace_uart_if.slave   bus
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [2:0]  LAST_B = 3'(FRAME_BYTES - 1);

  logic [SNAP_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [7:0]        prev_state;
  logic [SNAP_W-1:0] frame_q, snapshot;
  logic [2:0]        byte_idx;
  logic              active, active_nxt;
  logic              ovf_q, busy_q;
  logic              capture, full, pop, advance, finish, push, load;
  logic [7:0]        load_data;
  logic              tx_ready, tx_line;

  assign snapshot = {bus.R_IN, bus.FLAGS_IN, bus.STATE_IN};

  // Capture, FIFO and sequencing decisions. A pop frees a slot on the same
  // edge, so a full FIFO still accepts a snapshot when it is being popped.
  always_comb begin
    capture    = bus.EN && (bus.STATE_IN != prev_state);
    full       = (count == CNT_W'(DEPTH));
    pop        = !active && tx_ready && (count != '0);
    advance    = active && tx_ready && (byte_idx != LAST_B);
    finish     = active && tx_ready && (byte_idx == LAST_B);
    push       = capture && (!full || pop);
    load       = pop || advance;
    load_data  = pop ? SYNC_BYTE : frame_byte(frame_q, byte_idx + 3'd1);
    count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
    active_nxt = pop || (active && !finish);
  end

  // Snapshot storage.
  always_ff @(posedge CLK) begin
    if (NRST && push) mem[wr_ptr] <= snapshot;
  end

  // Control state: detector history, pointers, frame register, status flags.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      prev_state <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_q    <= '0;
      byte_idx   <= '0;
      active     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      prev_state <= bus.STATE_IN;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        frame_q  <= mem[rd_ptr];
        byte_idx <= '0;
      end else if (advance) begin
        byte_idx <= byte_idx + 1'b1;
      end
      count  <= count_nxt;
      active <= active_nxt;
      if (capture && !push)  ovf_q <= 1'b1;
      else if (bus.CLR_OVF)  ovf_q <= 1'b0;
      busy_q <= active_nxt || (count_nxt != '0);
    end
  end

  uart_tx8 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (CLK),
    .rst_n (NRST),
    .load  (load),
    .data  (load_data),
    .ready (tx_ready),
    .tx    (tx_line)
  );

  assign bus.TX   = tx_line;
  assign bus.BUSY = busy_q;
  assign bus.OVF  = ovf_q;

endmodule

// File: doc/nano_trace_uart.md
# nano_trace_uart

Debug trace streamer for the Nano microcontroller system. It watches the CPU monitor buses (state byte, flags byte, 32-bit R word) and snapshots all three whenever the state byte changes. Snapshots are buffered in a small FIFO and sent as fixed 7-byte frames over a UART 8N1 transmit line. It sits downstream of the Nano CPU and gives the host a full trace through one pin, instead of the output-select mux seeing one slice at a time.

## Interface
- `CLKS_PER_BIT`, default 27: CLK cycles per UART bit (57600 baud at 1.5625 MHz, 0.5 % error).
- `DEPTH`, default 4: snapshot FIFO entries; power of two, at least 2.
- `CLK`, in, 1: system clock, the same clock as the CPU.
- `NRST`, in, 1: reset, synchronous, active-low.
- `EN`, in, 1: enables capture; it does not gate a frame already in progress.
- `CLR_OVF`, in, 1: clears `OVF`; acts on any clock edge where it is high.
- `STATE_IN`, in, 8: CPU state byte.
- `FLAGS_IN`, in, 8: CPU flags byte.
- `R_IN`, in, 32: CPU R register.
- `TX`, out, 1: UART serial output; idles high.
- `BUSY`, out, 1: high while a frame is transmitting or the FIFO is non-empty.
- `OVF`, out, 1: sticky flag; set when a snapshot is dropped because the FIFO is full.

## Operation
- **Change detector.** Register `prev_state` loads `STATE_IN` on every edge. A capture is requested when `EN`=1 and `STATE_IN` differs from `prev_state`.
- **Snapshot.** One snapshot is 48 bits: {`R_IN`, `FLAGS_IN`, `STATE_IN`}, sampled on the same edge as the capture request.
- **FIFO write.**
  - A snapshot is written when a capture is requested and either count < `DEPTH`, or a pop happens on the same edge.
  - Otherwise the snapshot is dropped and `OVF` is set.
  - If `CLR_OVF` and a new overflow occur on the same edge, the overflow wins.
- **Frame format.** Bytes are sent in this order: 0xA5 (sync), state, flags, R[7:0], R[15:8], R[23:16], R[31:24].
- **Bit format.** Each byte is one start bit (0), 8 data bits LSB first, then one stop bit (1).
- **Transmit FSM states.**
  - IDLE: `TX`=1. If the FIFO is non-empty, pop into the frame register, set byte index to 0 and go to START.
  - START: `TX`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `TX` drives the current bit for `CLKS_PER_BIT` cycles per bit. After bit 7, go to STOP.
  - STOP: `TX`=1 for `CLKS_PER_BIT` cycles. If byte index < 6, increment it and go to START with no gap; otherwise go to IDLE.
- **Back-to-back frames.** IDLE lasts exactly one cycle when the FIFO is non-empty, so consecutive frames are separated by one idle-high cycle.
- **Frame content is frozen at pop.** Later input changes never alter a frame in flight.
- **Reset.** Applied at any edge with `NRST`=0, including mid-frame. It sets:
  - FSM to IDLE;
  - FIFO empty (pointers 0);
  - `prev_state` = 0x00;
  - `TX`=1, `BUSY`=0, `OVF`=0.
  An interrupted frame is abandoned, not completed.

## Timing
- All outputs are registered; `TX` comes directly from a flop.
- Capture latency: a state change present before edge N is written at edge N. The pop and the `TX` falling edge occur at edge N+1 if the FSM was idle.
- One byte takes 10·`CLKS_PER_BIT` cycles. One frame takes 70·`CLKS_PER_BIT` cycles, which is 1890 with the defaults.
- The first state after reset is captured if it is non-zero, because it differs from `prev_state` = 0x00.
- Sustained state changes faster than one per frame fill the FIFO within `DEPTH` frames; further snapshots are dropped and `OVF` is set.

## Structure
- Package `nano_trace_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - the constants SYNC_BYTE = 8'hA5, FRAME_BYTES = 7 and SNAP_W = 48.
- One natural sub-module, `uart_tx8`: a single-byte 8N1 serializer with a load/ready handshake and the `CLKS_PER_BIT` parameter. The top level owns the FIFO, the change detector and byte sequencing.
- The FIFO is inline: register array, read/write pointers, and a count of width clog2(`DEPTH`)+1.

## Test plan
1. Reset, then `STATE_IN` 0x00→0x11, with `FLAGS_IN`=0x3C and `R_IN`=0xDEADBEEF. Decode `TX`: A5 11 3C EF BE AD DE. `TX` falls at edge N+1; `BUSY` drops after 1890 cycles.
2. `EN`=0 while `STATE_IN` toggles 10 times: `TX` stays high and `BUSY` stays 0. Then `EN`=1 with one change: exactly one frame.
3. Six state changes one cycle apart, with `DEPTH`=4 and the FSM idle: the first is popped immediately and the next four are buffered, so all five frames are sent in order. The sixth is dropped and `OVF`=1. `CLR_OVF` pulse → `OVF`=0.
4. `NRST`=0 in the middle of the third byte of a frame: `TX`=1, `BUSY`=0 and FIFO empty at the next edge. No partial bytes appear after reset is released.
5. Overflow and `CLR_OVF` on the same edge: `OVF` stays 1.
6. Back-to-back frames: exactly one idle-high cycle between the stop bit of byte 6 and the next start bit.
